// File: rtl/rf_result_checker.sv
// rf_result_checker: walks a table of (register, expected value) pairs in order against the live
// register file, allowing each entry up to TIMEOUT non-matching samples before declaring failure.
module rf_result_checker #(
  parameter int DWIDTH  = 16,
  parameter int NREGS   = 4,
  parameter int NCHECKS = 8,
  parameter int TIMEOUT = 100,
  parameter int CNT_W   = 32,
  parameter int RI_W    = (NREGS > 1) ? $clog2(NREGS) : 1,
  parameter int CI_W    = (NCHECKS > 1) ? $clog2(NCHECKS) : 1,
  parameter int NC_W    = $clog2(NCHECKS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREGS*DWIDTH-1:0]   rf_flat,
  input  logic                      cfg_we,
  input  logic [CI_W-1:0]           cfg_idx,
  input  logic [RI_W-1:0]           cfg_reg,
  input  logic [DWIDTH-1:0]         cfg_val,
  input  logic [NC_W-1:0]           num_checks,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [CI_W-1:0]           fail_idx,
  output logic [DWIDTH-1:0]         fail_got,
  output logic [NC_W-1:0]           checks_passed,
  output logic [CNT_W-1:0]          cur_wait,
  output logic [CNT_W-1:0]          total_cycles
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;
  state_t r_state, w_next;
  logic [RI_W-1:0]   r_reg [NCHECKS];
  logic [DWIDTH-1:0] r_val [NCHECKS];
  logic [DWIDTH-1:0] w_regs [NREGS];
  logic [NC_W-1:0]   r_n, r_passed, w_n;
  logic [CI_W-1:0]   r_k, r_fail_idx;
  logic [DWIDTH-1:0] r_fail_got, w_got;
  logic [CNT_W-1:0]  r_wait, r_total;
  logic              r_busy, r_done, r_pass, r_fail;
  logic              w_match, w_last, w_timeout, w_start, w_cfg;
  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign w_regs[g] = rf_flat[g*DWIDTH +: DWIDTH];
  end
  assign w_got     = w_regs[r_reg[r_k]];
  assign w_match   = w_got == r_val[r_k];
  assign w_last    = NC_W'(r_k) + 1'b1 == r_n;
  assign w_timeout = r_wait == CNT_W'(TIMEOUT - 1);
  assign w_n       = (32'(num_checks) > NCHECKS) ? NC_W'(NCHECKS) : num_checks;
  assign w_start   = start && r_state != S_RUN;
  assign w_cfg     = cfg_we && r_state != S_RUN && 32'(cfg_idx) < NCHECKS;
  always_comb begin
    w_next = r_state;
    if (r_state == S_RUN) w_next = w_match ? (w_last ? S_PASS : S_RUN) : (w_timeout ? S_FAIL : S_RUN);
    else if (start) w_next = (w_n == '0) ? S_PASS : S_RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg      <= '{default: '0};
      r_val      <= '{default: '0};
      r_n        <= '0;
      r_k        <= '0;
      r_passed   <= '0;
      r_wait     <= '0;
      r_total    <= '0;
      r_fail_idx <= '0;
      r_fail_got <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_busy <= w_next == S_RUN;
      r_done <= w_next == S_PASS || w_next == S_FAIL;
      r_pass <= w_next == S_PASS;
      r_fail <= w_next == S_FAIL;
      if (w_cfg) begin
        r_reg[cfg_idx] <= cfg_reg;
        r_val[cfg_idx] <= cfg_val;
      end
      if (w_start) begin
        r_n        <= w_n;
        r_k        <= '0;
        r_passed   <= '0;
        r_wait     <= '0;
        r_total    <= '0;
        r_fail_idx <= '0;
        r_fail_got <= '0;
      end else if (r_state == S_RUN) begin
        r_total <= (&r_total) ? r_total : r_total + 1'b1;
        if (w_match) begin
          r_passed <= (&r_passed) ? r_passed : r_passed + 1'b1;
          r_wait   <= '0;
          r_k      <= w_last ? r_k : r_k + 1'b1;
        end else if (w_timeout) begin
          r_fail_idx <= r_k;
          r_fail_got <= w_got;
        end else begin
          r_wait <= (&r_wait) ? r_wait : r_wait + 1'b1;
        end
      end
    end
  end
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign fail          = r_fail;
  assign fail_idx      = r_fail_idx;
  assign fail_got      = r_fail_got;
  assign checks_passed = r_passed;
  assign cur_wait      = r_wait;
  assign total_cycles  = r_total;
endmodule

// File: doc/rf_result_checker.md
Name: rf_result_checker

Overview:
- Synthesizable self-checking monitor for the CPU register file; replaces hand-written bench polling of register values.
- Holds a table of up to NCHECKS expected results, each an (register index, expected value) pair.
- On start, evaluates the entries in order against the live register file, with a per-entry cycle timeout.
- Reports pass/fail, the failing entry, the value seen, and cycle statistics.
- Sits beside cpu_top and taps the register-file outputs through a flat bus.

Parameters:
- DWIDTH, 16, register data width.
- NREGS, 4, number of architectural registers on rf_flat.
- NCHECKS, 8, depth of the expected-result table.
- TIMEOUT, 100, maximum non-matching samples allowed per entry before failing (must be >=1).
- CNT_W, 32, width of the cycle counters.
- Derived: RI_W = max(1, clog2(NREGS)); CI_W = max(1, clog2(NCHECKS)); NC_W = clog2(NCHECKS+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- rf_flat  in  NREGS*DWIDTH  live register values; register r occupies bits [r*DWIDTH +: DWIDTH].
- cfg_we  in  1  table write strobe.
- cfg_idx  in  CI_W  table entry to write.
- cfg_reg  in  RI_W  register index for the entry.
- cfg_val  in  DWIDTH  expected value for the entry.
- num_checks  in  NC_W  number of entries to run; sampled on start.
- start  in  1  one-cycle pulse that begins a run.
- busy  out  1  high while in RUN.
- done  out  1  high in PASS or FAIL; held until the next start or reset.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- fail_idx  out  CI_W  entry that timed out.
- fail_got  out  DWIDTH  register value seen on the final failing sample.
- checks_passed  out  NC_W  count of entries matched in the current or last run.
- cur_wait  out  CNT_W  non-matching samples taken on the current entry.
- total_cycles  out  CNT_W  cycles spent in RUN during the current or last run.

Behaviour:
- Reset: FSM goes to IDLE. Every output is 0. All table entries are cleared to reg=0, val=0. Reset is honoured mid-run with no residual state.
- FSM states and transitions:
  - IDLE: on start, go to RUN.
  - RUN: evaluate entries as below.
  - PASS, FAIL: on start, go to RUN.
- Start handling:
  - start while in RUN is ignored.
  - On entering RUN: latch n = min(num_checks, NCHECKS). Set k=0 and clear checks_passed, cur_wait and total_cycles.
  - If n == 0 at start, go directly to PASS on the next edge, with busy never asserted and total_cycles = 0.
- Table writes:
  - cfg_we writes entry cfg_idx in IDLE, PASS or FAIL.
  - cfg_we is ignored in RUN.
  - cfg_idx >= NCHECKS is ignored.
  - A write and a start in the same cycle: the write commits first and is used by the run.
- RUN, each rising edge:
  - total_cycles increments.
  - Sample got = rf_flat[reg_k] (the value visible before the edge).
  - If got == val_k: checks_passed increments and cur_wait clears. If k == n-1, go to PASS; otherwise k increments.
  - Else, if cur_wait == TIMEOUT-1: go to FAIL with fail_idx=k and fail_got=got.
  - Else: cur_wait increments.
- Timing consequences:
  - An entry already matching when reached costs exactly 1 cycle.
  - An entry never matching fails after exactly TIMEOUT samples.
- Ordering: entries are strictly sequential. A later entry's register matching early does not count; it is evaluated only when reached.
- Outputs are registered and update on the same edge as the state change.
- pass/fail and the statistics hold their values until the next start.
- Counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Basic pass: registers x0..x3 = 0,1,4,2; entries {x2,4},{x3,2}; n=2; pulse start -> PASS two cycles later, checks_passed=2, total_cycles=2.
- Delayed match: entry {x1,2}; x1 is driven to 2 five cycles after start -> PASS, total_cycles=6, cur_wait=0.
- Timeout: TIMEOUT=100, entry {x0,7}, x0 held at 0 -> FAIL exactly 100 cycles after start, fail_idx=0, fail_got=0, checks_passed=0.
- Second entry fails: entries {x1,1},{x2,9} with x2=4 -> FAIL, fail_idx=1, fail_got=4, checks_passed=1, total_cycles=101.
- Edge cases:
  - n=0 -> PASS one cycle after start with busy never high.
  - start during RUN is ignored.
  - cfg_we during RUN leaves the table unchanged, confirmed by rerunning.
- Reset and restart: assert rst mid-run -> all outputs 0 and the table is cleared. Reprogram the table and start again -> the run behaves as on a fresh part.
